// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiply-accumulate datapath.
// This package holds the controller state encodings and the default widths.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int N_DEF     = 4;
    localparam int ACC_W_DEF = 12;
    localparam int LEN_DEF   = 4;

    // Saturation bounds of the default accumulator width.
    localparam int SAT_MAX = (2 ** (ACC_W_DEF - 1)) - 1;
    localparam int SAT_MIN = -(2 ** (ACC_W_DEF - 1));

endpackage

// File: rtl/booth_product_accumulator_sat_add.sv
// Combinational signed saturating adder.
// The sum clamps to the most positive or most negative W-bit value on overflow.
module sat_add #(
    parameter int W = 12
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         ovf_o
);

    logic [W-1:0] raw;

    assign raw = a_i + b_i;

    // Overflow is only possible when both operands have the same sign.
    assign ovf_o = (a_i[W-1] == b_i[W-1]) && (raw[W-1] != a_i[W-1]);

    always_comb begin
        sum_o = raw;
        if (ovf_o) begin
            sum_o = a_i[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/booth_product_accumulator.sv
// Accumulates batches of LEN signed Booth products into a saturating sum.
// Each completed sum is handed on through a valid/ready handshake.
module booth_product_accumulator
    import booth_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN   = LEN_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N-1:0]              prod_hi,
    input  logic [N-1:0]              prod_lo,
    input  logic                      prod_valid,
    output logic                      prod_ready,
    input  logic                      clear,
    output logic [ACC_W-1:0]          acc_out,
    output logic                      acc_valid,
    input  logic                      acc_ready,
    output logic                      overflow,
    output logic [$clog2(LEN+1)-1:0]  count
);

    localparam int CW = $clog2(LEN + 1);

    state_e                  state_q, state_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;

    logic signed [2*N-1:0]   prod_s;
    logic signed [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0]        sum;
    logic                    sum_ovf;
    logic                    accept;

    assign prod_s   = {prod_hi, prod_lo};
    assign prod_ext = ACC_W'(prod_s);

    sat_add #(.W(ACC_W)) u_sat_add (
        .a_i   (acc_q),
        .b_i   (prod_ext),
        .sum_o (sum),
        .ovf_o (sum_ovf)
    );

    assign prod_ready = (state_q == ACC);
    assign acc_valid  = (state_q == DONE);
    assign accept     = prod_valid && prod_ready;
    assign acc_out    = acc_q;
    assign overflow   = ovf_q;
    assign count      = cnt_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: state_d = ACC;
            ACC: begin
                if (accept) begin
                    acc_d = sum;
                    cnt_d = cnt_q + CW'(1);
                    ovf_d = ovf_q | sum_ovf;
                    if (cnt_q == CW'(LEN - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (acc_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ACC;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over any accept or handoff in the same cycle.
        if (clear) begin
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = ACC;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Directed bench for booth_product_accumulator: a 12-bit and an 8-bit
// accumulator instance share clock, reset and product halves.
module tb_booth_product_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  prod_hi = '0;
    logic [3:0]  prod_lo = '0;

    logic        valid_a = 1'b0, clear_a = 1'b0, ardy_a = 1'b0;
    logic        pready_a, avalid_a, ovf_a;
    logic [11:0] acc_a;
    logic [2:0]  cnt_a;

    logic        valid_b = 1'b0, clear_b = 1'b0, ardy_b = 1'b0;
    logic        pready_b, avalid_b, ovf_b;
    logic [7:0]  acc_b;
    logic [2:0]  cnt_b;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    booth_product_accumulator #(.N(4), .ACC_W(12), .LEN(4)) dut_a (
        .clk(clk), .rst(rst), .prod_hi(prod_hi), .prod_lo(prod_lo),
        .prod_valid(valid_a), .prod_ready(pready_a), .clear(clear_a),
        .acc_out(acc_a), .acc_valid(avalid_a), .acc_ready(ardy_a),
        .overflow(ovf_a), .count(cnt_a)
    );

    booth_product_accumulator #(.N(4), .ACC_W(8), .LEN(4)) dut_b (
        .clk(clk), .rst(rst), .prod_hi(prod_hi), .prod_lo(prod_lo),
        .prod_valid(valid_b), .prod_ready(pready_b), .clear(clear_b),
        .acc_out(acc_b), .acc_valid(avalid_b), .acc_ready(ardy_b),
        .overflow(ovf_b), .count(cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_prod(input logic [3:0] hi, input logic [3:0] lo);
        prod_hi = hi;
        prod_lo = lo;
    endtask

    initial begin
        #2 rst = 1'b0;
        #1;
        chk("rst_acc", acc_a, 32'h0);
        chk("rst_valid", avalid_a, 32'h0);
        chk("rst_pready", pready_a, 32'h0);
        chk("rst_ovf", ovf_a, 32'h0);
        chk("rst_cnt", cnt_a, 32'h0);
        step();
        step();
        @(negedge clk) rst = 1'b1;
        #1;
        chk("idle_pready", pready_a, 32'h0);
        step();
        chk("acc_pready", pready_a, 32'h1);

        // Basic batch: four 7x7 products.
        set_prod(4'h3, 4'h1);
        valid_a = 1'b1;
        step(); chk("basic_acc1", acc_a, 32'd49);  chk("basic_cnt1", cnt_a, 32'd1);
        step(); chk("basic_acc2", acc_a, 32'd98);
        step(); chk("basic_acc3", acc_a, 32'd147); chk("basic_valid3", avalid_a, 32'h0);
        step();
        valid_a = 1'b0;
        chk("basic_acc4", acc_a, 32'h0C4);
        chk("basic_valid4", avalid_a, 32'h1);
        chk("basic_ovf", ovf_a, 32'h0);

        // Backpressure: the result holds while the consumer stalls.
        ardy_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_acc", acc_a, 32'h0C4);
            chk("bp_cnt", cnt_a, 32'd4);
            chk("bp_valid", avalid_a, 32'h1);
            chk("bp_pready", pready_a, 32'h0);
        end
        ardy_a = 1'b1;
        step();
        ardy_a = 1'b0;
        chk("ho_acc", acc_a, 32'h0);
        chk("ho_cnt", cnt_a, 32'd0);
        chk("ho_pready", pready_a, 32'h1);
        chk("ho_valid", avalid_a, 32'h0);

        // Signed mix: 49, -56, 49, -56.
        valid_a = 1'b1;
        set_prod(4'h3, 4'h1); step(); chk("mix_acc1", acc_a, 32'h031);
        set_prod(4'hC, 4'h8); step(); chk("mix_acc2", acc_a, 32'hFF9);
        set_prod(4'h3, 4'h1); step(); chk("mix_acc3", acc_a, 32'h02A);
        set_prod(4'hC, 4'h8); step();
        valid_a = 1'b0;
        chk("mix_acc4", acc_a, 32'hFF2);
        chk("mix_valid", avalid_a, 32'h1);
        chk("mix_ovf", ovf_a, 32'h0);
        ardy_a = 1'b1;
        step();
        ardy_a = 1'b0;
        chk("mix_ho_valid", avalid_a, 32'h0);

        // Clear mid-batch drops the product offered alongside it.
        valid_a = 1'b1;
        set_prod(4'h3, 4'h1);
        step();
        step();
        chk("clr_pre_cnt", cnt_a, 32'd2);
        clear_a = 1'b1;
        step();
        clear_a = 1'b0;
        valid_a = 1'b0;
        chk("clr_acc", acc_a, 32'h0);
        chk("clr_cnt", cnt_a, 32'd0);
        chk("clr_ovf", ovf_a, 32'h0);
        chk("clr_pready", pready_a, 32'h1);
        set_prod(4'h0, 4'h7);
        valid_a = 1'b1;
        step();
        chk("post_clr_acc", acc_a, 32'd7);
        chk("post_clr_cnt", cnt_a, 32'd1);
        step(); step(); step();
        valid_a = 1'b0;
        chk("fill_acc", acc_a, 32'd28);
        chk("fill_valid", avalid_a, 32'h1);

        // Reset while a result is presented.
        #2 rst = 1'b0;
        #1;
        chk("mr_valid", avalid_a, 32'h0);
        chk("mr_pready", pready_a, 32'h0);
        chk("mr_acc", acc_a, 32'h0);
        chk("mr_cnt", cnt_a, 32'd0);
        step();
        @(negedge clk) rst = 1'b1;
        #1;
        chk("mr_idle_pready", pready_a, 32'h0);
        step();
        chk("mr_acc_pready", pready_a, 32'h1);

        // Saturation in the 8-bit instance: 49 four times.
        set_prod(4'h3, 4'h1);
        valid_b = 1'b1;
        step(); chk("sat_acc1", acc_b, 32'd49);  chk("sat_ovf1", ovf_b, 32'h0);
        step(); chk("sat_acc2", acc_b, 32'd98);  chk("sat_ovf2", ovf_b, 32'h0);
        step(); chk("sat_acc3", acc_b, 32'h7F);  chk("sat_ovf3", ovf_b, 32'h1);
        step();
        valid_b = 1'b0;
        chk("sat_acc4", acc_b, 32'h7F);
        chk("sat_ovf4", ovf_b, 32'h1);
        chk("sat_valid", avalid_b, 32'h1);
        step();
        chk("sat_hold_ovf", ovf_b, 32'h1);
        ardy_b = 1'b1;
        step();
        ardy_b = 1'b0;
        chk("sat_ho_ovf", ovf_b, 32'h0);
        chk("sat_ho_acc", acc_b, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/booth_product_accumulator.md
# booth_product_accumulator

Downstream stage for the Booth multiplier: consumes signed 2N-bit products (presented as high/low N-bit halves), accumulates a fixed-length batch of LEN products into a signed ACC_W-bit saturating accumulator, and hands the batch sum on through a valid/ready handshake. Together with the multiplier it forms a small multiply-accumulate datapath (dot-product of LEN operand pairs).

## Interface
Parameters:
- N, 4: multiplier operand width; product is 2N bits.
- ACC_W, 12: accumulator width; must be ≥ 2N.
- LEN, 4: products per batch; must be ≥ 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- prod_hi  input  N  product upper half; MSB is the sign bit.
- prod_lo  input  N  product lower half.
- prod_valid  input  1  product halves are valid.
- prod_ready  output  1  block accepts a product this cycle.
- clear  input  1  synchronous batch abort/restart.
- acc_out  output  ACC_W  batch sum, signed.
- acc_valid  output  1  acc_out holds a completed batch.
- acc_ready  input  1  consumer takes acc_out.
- overflow  output  1  sticky; saturation occurred in the current/presented batch.
- count  output  $clog2(LEN+1)  products accepted in the current batch.

## Operation
- States: IDLE, ACC, DONE. Reset enters IDLE; IDLE → ACC unconditionally on the first clock after reset release.
- prod_ready = (state == ACC); decoded from the state register only, never from prod_valid.
- Accept = prod_valid && prod_ready. On accept: p = signed {prod_hi, prod_lo}, sign-extended to ACC_W; acc ← sat(acc + p); count ← count + 1.
- Saturation: if the signed sum exceeds 2^(ACC_W-1)-1 or falls below -2^(ACC_W-1), clamp to that bound and set overflow. overflow stays set until the batch is handed off or cleared.
- When the accept raises count to LEN: state → DONE and acc_valid = 1.
- DONE: acc_out, overflow, and count (= LEN) are held stable; prod_ready = 0. When acc_ready = 1: acc, count, and overflow → 0; acc_valid → 0; state → ACC.
- clear (any state except reset): acc, count, overflow → 0; acc_valid → 0; state → ACC. clear overrides a simultaneous accept or handoff; the product offered in that cycle is dropped.
- acc_out always equals the accumulator register and reads 0 after reset/clear.

## Timing
- Reset values (asynchronous, while rst = 0): state IDLE, acc_out 0, acc_valid 0, prod_ready 0, overflow 0, count 0.
- First product can be accepted on the 2nd rising edge after rst deasserts.
- Throughput: one product per cycle in ACC. The sum is visible on acc_out one cycle after accept.
- acc_valid rises on the cycle after the LEN-th accept. Minimum one bubble: prod_ready is low for ≥ 1 cycle per batch, while in DONE.
- Handoff occurs on the edge where acc_valid && acc_ready. prod_ready is high on the following cycle.
- acc_ready while not in DONE has no effect.
- Reset asserted mid-batch or in DONE discards everything immediately, with no handoff.

## Structure
- Shared package/header (booth_pkg): state encodings IDLE/ACC/DONE, plus helper constants SAT_MAX/SAT_MIN derived from ACC_W. The multiplier and its testbench reuse the same header for N.
- One sub-module: sat_add, a parameterised combinational signed saturating adder (ACC_W-bit inputs) with a sum and an ovf flag. All state, counting, and handshake logic stays in the top.

## Test plan
- Basic batch: N=4, ACC_W=12, LEN=4; four products 7×7 (prod_hi=4'h3, prod_lo=4'h1). Required: acc_out = 196 (12'h0C4), acc_valid = 1 the cycle after the 4th accept, overflow = 0.
- Signed mix: products 49, -56 ({4'hC,4'h8}), 49, -56. Required: acc_out = -14 (12'hFF2), overflow = 0.
- Saturation: ACC_W=8, four products of 49. Required: acc_out = 127 (8'h7F), overflow = 1 from the 3rd accept until handoff.
- Backpressure: after batch complete, hold acc_ready = 0 for 3 cycles. Required: acc_out, count = 4, and acc_valid are stable and prod_ready = 0; then pulse acc_ready. Required: the next cycle has acc_out = 0, count = 0, prod_ready = 1.
- Clear mid-batch: after 2 accepts, assert clear together with prod_valid. Required: next cycle acc_out = 0, count = 0, overflow = 0, and the offered product is not counted.
- Reset mid-operation: drop rst in DONE. Required: all outputs go to reset values immediately (acc_valid = 0, prod_ready = 0); after release, one IDLE cycle, then prod_ready = 1.
